// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, permutations and the schedule FSM state type.
package des_pkg;
    localparam int DES_KEY_W    = 64;
    localparam int DES_CD_W     = 56;
    localparam int DES_SUBKEY_W = 48;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam logic [1:0] DES_SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Table entries are 1-based DES bit numbers; bit 1 is the MSB of the vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [DES_CD_W-1:0] pc1(input logic [DES_KEY_W-1:0] key);
        logic [DES_CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < DES_CD_W; i++)
            cd[6'(DES_CD_W - 1 - i)] = key[6'(DES_KEY_W - PC1_TAB[6'(i)])];
        return cd;
    endfunction

    function automatic logic [DES_SUBKEY_W-1:0] pc2(input logic [DES_CD_W-1:0] cd);
        logic [DES_SUBKEY_W-1:0] sk;
        sk = '0;
        for (int i = 0; i < DES_SUBKEY_W; i++)
            sk[6'(DES_SUBKEY_W - 1 - i)] = cd[6'(DES_CD_W - PC2_TAB[6'(i)])];
        return sk;
    endfunction

    // Rotate C and D independently by 1 or 2 places.
    function automatic logic [DES_CD_W-1:0] rot_cd(input logic [DES_CD_W-1:0] cd,
                                                   input logic [1:0] amt,
                                                   input logic left);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (left) begin
            if (amt == 2'd2) begin
                c = {c[25:0], c[27:26]};
                d = {d[25:0], d[27:26]};
            end else begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end else begin
            if (amt == 2'd2) begin
                c = {c[1:0], c[27:2]};
                d = {d[1:0], d[27:2]};
            end else begin
                c = {c[0], c[27:1]};
                d = {d[0], d[27:1]};
            end
        end
        return {c, d};
    endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// Start/key request and subkey valid/ready stream between a round engine and the key schedule.
interface des_key_schedule_if;
    import des_pkg::*;

    logic                    i_start;
    logic [DES_KEY_W-1:0]    i_key;
    logic                    i_decrypt;
    logic                    o_busy;
    logic                    o_subkey_valid;
    logic                    i_subkey_ready;
    logic [DES_SUBKEY_W-1:0] o_subkey;
    logic [3:0]              o_round;
    logic                    o_done;

    modport master (
        output i_start, i_key, i_decrypt, i_subkey_ready,
        input  o_busy, o_subkey_valid, o_subkey, o_round, o_done
    );

    modport slave (
        input  i_start, i_key, i_decrypt, i_subkey_ready,
        output o_busy, o_subkey_valid, o_subkey, o_round, o_done
    );
endinterface

// File: rtl/des_pc2.sv
// PC-2 compression of the 56-bit C/D state into a 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [DES_CD_W-1:0]     i_cd,
    output logic [DES_SUBKEY_W-1:0] o_subkey
);
    always_comb o_subkey = pc2(i_cd);
endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one subkey per handshake, encrypt or decrypt order,
// decrypt order obtained by right-rotating C/D instead of storing a subkey table.
module des_key_schedule
    import des_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    des_key_schedule_if.slave bus
);
    state_e                  state_q, state_d;
    logic [DES_CD_W-1:0]     cd_q, cd_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    dec_q, dec_d;
    logic                    done_q, done_d;
    logic [DES_SUBKEY_W-1:0] pc2_out;
    logic                    run;
    logic                    hs;
    logic [1:0]              step;

    des_pc2 u_pc2 (
        .i_cd     (cd_q),
        .o_subkey (pc2_out)
    );

    assign run = (state_q == RUN);
    assign hs  = run && bus.i_subkey_ready;

    // Encrypt looks one entry ahead in the table; decrypt walks it from the end.
    assign step = dec_q ? DES_SHIFTS[4'd15 - cnt_q] : DES_SHIFTS[cnt_q + 4'd1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    // C0D0 is already K16's state; encrypt pre-applies s1 to reach K1.
                    cd_d    = bus.i_decrypt ? pc1(bus.i_key)
                                            : rot_cd(pc1(bus.i_key), 2'd1, 1'b1);
                    cnt_d   = '0;
                    dec_d   = bus.i_decrypt;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        cd_d  = rot_cd(cd_q, step, !dec_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy         = run;
    assign bus.o_subkey_valid = run;
    assign bus.o_subkey       = run ? pc2_out : '0;
    assign bus.o_round        = run ? (dec_q ? (4'd15 - cnt_q) : cnt_q) : 4'd0;
    assign bus.o_done         = done_q;
endmodule
